// File: rtl/sw_cmd_arbiter.sv
// ============================================================================
// Module   : sw_cmd_arbiter
// Brief    : Arbitrates run configuration between panel switches and UART
//            console, with ownership timeout and a 3-byte status report.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module sw_cmd_arbiter #(
    parameter int OWN_TIMEOUT = 500_000_000,
    parameter int TO_W        = 29
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       rx_done,
    input  logic [7:0] rx_data,
    input  logic [1:0] sw_phy,
    input  logic       tx_busy,
    output logic       tx_start,
    output logic [7:0] tx_data,
    output logic [1:0] cfg,
    output logic       owner,
    output logic       cmd_drop
);

    localparam logic [7:0]      C_CMD_N   = 8'h6E;
    localparam logic [7:0]      C_CMD_M   = 8'h6D;
    localparam logic [7:0]      C_CMD_P   = 8'h70;
    localparam logic [7:0]      C_CMD_Q   = 8'h3F;
    localparam logic [7:0]      C_ASCII_0 = 8'h30;
    localparam logic [7:0]      C_LF      = 8'h0A;
    localparam logic [TO_W-1:0] C_TO_LAST = TO_W'(OWN_TIMEOUT - 1);

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_LOAD  = 3'd1,
        ST_START = 3'd2,
        ST_ACK   = 3'd3,
        ST_DONE  = 3'd4
    } state_t;

    logic [1:0]      sw_meta_q, sw_s_q, sw_prev_q;
    logic [1:0]      cfg_q, cfg_d;
    logic            owner_q, owner_d;
    logic            cmd_drop_q, cmd_drop_d;
    logic [TO_W-1:0] timer_q, timer_d;
    state_t          state_q, state_d;
    logic            pend_q, pend_d;
    logic [1:0]      snap_q, snap_d;
    logic [1:0]      idx_q, idx_d;
    logic            tx_start_q, tx_start_d;
    logic [7:0]      tx_data_q, tx_data_d;

    logic            phy_chg;
    logic            cmd_n, cmd_m, cmd_p, cmd_q;
    logic            expire;
    logic            report_req;
    logic [7:0]      cur_byte;

    assign phy_chg = (sw_s_q != sw_prev_q);
    assign cmd_n   = rx_done && (rx_data == C_CMD_N);
    assign cmd_m   = rx_done && (rx_data == C_CMD_M);
    assign cmd_p   = rx_done && (rx_data == C_CMD_P);
    assign cmd_q   = rx_done && (rx_data == C_CMD_Q);

    // Panel change outranks every UART command; timer only runs while UART owns cfg.
    always_comb begin
        cfg_d      = cfg_q;
        owner_d    = owner_q;
        timer_d    = timer_q;
        cmd_drop_d = 1'b0;
        expire     = 1'b0;
        if (phy_chg) begin
            cfg_d      = sw_s_q;
            owner_d    = 1'b0;
            timer_d    = '0;
            cmd_drop_d = cmd_n | cmd_m | cmd_p;
        end else if (cmd_n) begin
            cfg_d[1] = ~cfg_q[1];
            owner_d  = 1'b1;
            timer_d  = '0;
        end else if (cmd_m) begin
            cfg_d[0] = ~cfg_q[0];
            owner_d  = 1'b1;
            timer_d  = '0;
        end else if (cmd_p) begin
            cfg_d   = sw_s_q;
            owner_d = 1'b0;
            timer_d = '0;
        end else if (owner_q) begin
            if (timer_q == C_TO_LAST) begin
                cfg_d   = sw_s_q;
                owner_d = 1'b0;
                timer_d = '0;
                expire  = 1'b1;
            end else begin
                timer_d = timer_q + 1'b1;
            end
        end else begin
            timer_d = '0;
        end
        report_req = (cfg_d != cfg_q) | (owner_d != owner_q) | expire | cmd_q;
    end

    always_comb begin
        case (idx_q)
            2'd0:    cur_byte = C_ASCII_0 + {7'd0, snap_q[1]};
            2'd1:    cur_byte = C_ASCII_0 + {7'd0, snap_q[0]};
            default: cur_byte = C_LF;
        endcase
    end

    always_comb begin
        state_d    = state_q;
        pend_d     = pend_q;
        snap_d     = snap_q;
        idx_d      = idx_q;
        tx_start_d = 1'b0;
        tx_data_d  = tx_data_q;
        if (report_req && (state_q != ST_IDLE)) begin
            pend_d = 1'b1;
        end
        case (state_q)
            ST_IDLE: begin
                if (report_req || pend_q) begin
                    state_d = ST_LOAD;
                    pend_d  = 1'b0;
                end
            end
            ST_LOAD: begin
                snap_d  = cfg_q;
                idx_d   = 2'd0;
                state_d = ST_START;
            end
            ST_START: begin
                if (!tx_busy) begin
                    tx_start_d = 1'b1;
                    tx_data_d  = cur_byte;
                    state_d    = ST_ACK;
                end
            end
            ST_ACK: begin
                if (tx_busy) begin
                    state_d = ST_DONE;
                end
            end
            ST_DONE: begin
                if (!tx_busy) begin
                    if (idx_q == 2'd2) begin
                        state_d = ST_IDLE;
                    end else begin
                        idx_d   = idx_q + 2'd1;
                        state_d = ST_START;
                    end
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            sw_meta_q  <= 2'b00;
            sw_s_q     <= 2'b00;
            sw_prev_q  <= 2'b00;
            cfg_q      <= 2'b00;
            owner_q    <= 1'b0;
            cmd_drop_q <= 1'b0;
            timer_q    <= '0;
            state_q    <= ST_IDLE;
            pend_q     <= 1'b0;
            snap_q     <= 2'b00;
            idx_q      <= 2'd0;
            tx_start_q <= 1'b0;
            tx_data_q  <= 8'h00;
        end else begin
            sw_meta_q  <= sw_phy;
            sw_s_q     <= sw_meta_q;
            sw_prev_q  <= sw_s_q;
            cfg_q      <= cfg_d;
            owner_q    <= owner_d;
            cmd_drop_q <= cmd_drop_d;
            timer_q    <= timer_d;
            state_q    <= state_d;
            pend_q     <= pend_d;
            snap_q     <= snap_d;
            idx_q      <= idx_d;
            tx_start_q <= tx_start_d;
            tx_data_q  <= tx_data_d;
        end
    end

    assign cfg      = cfg_q;
    assign owner    = owner_q;
    assign cmd_drop = cmd_drop_q;
    assign tx_start = tx_start_q;
    assign tx_data  = tx_data_q;

endmodule

`default_nettype wire

// File: tb/tb_sw_cmd_arbiter.sv
// ============================================================================
// Module   : tb_sw_cmd_arbiter
// Brief    : Scoreboard bench for sw_cmd_arbiter with a transaction-level
//            reference model and a modelled UART transmitter.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_sw_cmd_arbiter;

    localparam int TO  = 16;
    localparam int TOW = 5;

    localparam logic [7:0] K_N = 8'h6E;
    localparam logic [7:0] K_M = 8'h6D;
    localparam logic [7:0] K_P = 8'h70;
    localparam logic [7:0] K_Q = 8'h3F;
    localparam logic [7:0] K_X = 8'h78;

    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic       rx_done = 1'b0;
    logic [7:0] rx_data = 8'h00;
    logic [1:0] sw_phy = 2'b00;
    logic       tx_busy = 1'b0;
    logic       tx_start;
    logic [7:0] tx_data;
    logic [1:0] cfg;
    logic       owner;
    logic       cmd_drop;

    sw_cmd_arbiter #(.OWN_TIMEOUT(TO), .TO_W(TOW)) dut (
        .clk      (clk),
        .rst      (rst),
        .rx_done  (rx_done),
        .rx_data  (rx_data),
        .sw_phy   (sw_phy),
        .tx_busy  (tx_busy),
        .tx_start (tx_start),
        .tx_data  (tx_data),
        .cfg      (cfg),
        .owner    (owner),
        .cmd_drop (cmd_drop)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;
    int nstart = 0;

    typedef struct packed {
        logic [1:0] cfg;
        logic       owner;
        logic       drop;
        logic       in_rst;
    } exp_t;

    exp_t       exp_q[$];
    logic [7:0] byte_q[$];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, req, $time);
        end
    endtask

    task automatic bound_fail(input string name);
        checks++;
        errors++;
        $display("FAIL %s: wait bound expired at %0t", name, $time);
    endtask

    // Reference model: sw history stands in for the synchronizer delay.
    logic [1:0] h0 = 2'b00, h1 = 2'b00, h2 = 2'b00;
    logic [1:0] m_cfg = 2'b00;
    logic       m_own = 1'b0;
    int         m_tcnt = 0;
    logic       m_active = 1'b0, m_pend = 1'b0, m_bprev = 1'b0;
    int         m_falls = 0;

    always @(posedge clk) begin : p_model
        logic [1:0] ncfg;
        logic       nown, drop, expire, req, pc;
        exp_t       e;
        if (!rst) begin
            h0 = 2'b00; h1 = 2'b00; h2 = 2'b00;
            m_cfg = 2'b00; m_own = 1'b0; m_tcnt = 0;
            m_active = 1'b0; m_pend = 1'b0; m_falls = 0;
            m_bprev = tx_busy;
            byte_q.delete();
            e = '{cfg: 2'b00, owner: 1'b0, drop: 1'b0, in_rst: 1'b1};
            exp_q.push_back(e);
        end else begin
            pc = (h1 != h2);
            ncfg = m_cfg; nown = m_own; drop = 1'b0; expire = 1'b0;
            if (pc) begin
                ncfg = h1; nown = 1'b0; m_tcnt = 0;
                drop = rx_done && (rx_data inside {K_N, K_M, K_P});
            end else if (rx_done && rx_data == K_N) begin
                ncfg = {~m_cfg[1], m_cfg[0]}; nown = 1'b1; m_tcnt = 0;
            end else if (rx_done && rx_data == K_M) begin
                ncfg = {m_cfg[1], ~m_cfg[0]}; nown = 1'b1; m_tcnt = 0;
            end else if (rx_done && rx_data == K_P) begin
                ncfg = h1; nown = 1'b0; m_tcnt = 0;
            end else if (m_own) begin
                if (m_tcnt == TO - 1) begin
                    ncfg = h1; nown = 1'b0; m_tcnt = 0; expire = 1'b1;
                end else begin
                    m_tcnt++;
                end
            end
            req = (ncfg != m_cfg) || (nown != m_own) || expire ||
                  (rx_done && rx_data == K_Q);
            if (!m_active) begin
                if (req || m_pend) begin
                    m_active = 1'b1; m_pend = 1'b0; m_falls = 0;
                    byte_q.push_back(8'h30 + {7'd0, ncfg[1]});
                    byte_q.push_back(8'h30 + {7'd0, ncfg[0]});
                    byte_q.push_back(8'h0A);
                end
            end else begin
                if (req) m_pend = 1'b1;
                if (m_bprev && !tx_busy) begin
                    m_falls++;
                    if (m_falls == 3) m_active = 1'b0;
                end
            end
            m_bprev = tx_busy;
            m_cfg = ncfg; m_own = nown;
            e = '{cfg: ncfg, owner: nown, drop: drop, in_rst: 1'b0};
            exp_q.push_back(e);
            h2 = h1; h1 = h0; h0 = sw_phy;
        end
    end

    always @(posedge clk) begin : p_monitor
        exp_t e;
        #1;
        if (exp_q.size() == 0) begin
            bound_fail("exp_queue_empty");
        end else begin
            e = exp_q.pop_front();
            chk("cfg", 32'(cfg), 32'(e.cfg));
            chk("owner", 32'(owner), 32'(e.owner));
            chk("cmd_drop", 32'(cmd_drop), 32'(e.drop));
            if (e.in_rst) begin
                chk("rst_tx_start", 32'(tx_start), 32'd0);
                chk("rst_tx_data", 32'(tx_data), 32'h00);
            end
        end
    end

    int         busy_cnt = 0;
    logic [7:0] held = 8'h00;
    logic       held_valid = 1'b0;

    always @(posedge clk) begin : p_uart_tx
        #1;
        if (!rst) held_valid = 1'b0;
        if (tx_start) begin
            chk("tx_start_while_busy", 32'(tx_busy), 32'd0);
            chk("tx_start_in_reset", 32'(rst), 32'd1);
            if (byte_q.size() == 0) bound_fail("unexpected_tx_start");
            else chk("tx_byte", 32'(tx_data), 32'(byte_q.pop_front()));
            nstart++;
            busy_cnt = $urandom_range(1, 6);
            held = tx_data;
            held_valid = 1'b1;
        end else begin
            if (tx_busy && held_valid && rst) chk("tx_data_hold", 32'(tx_data), 32'(held));
            if (busy_cnt > 0) busy_cnt--;
        end
        tx_busy = (busy_cnt != 0);
    end

    task automatic send(input logic [7:0] b);
        @(negedge clk);
        rx_data = b;
        rx_done = 1'b1;
        @(negedge clk);
        rx_done = 1'b0;
    endtask

    task automatic wait_quiet();
        int k;
        k = 0;
        repeat (TO + 4) @(negedge clk);
        while ((m_active || m_pend) && k < 2000) begin
            @(negedge clk);
            k++;
        end
        if (k >= 2000) bound_fail("quiesce");
        repeat (2) @(negedge clk);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int n0, c, r, sel;
        logic [7:0] cmds [6];
        cmds = '{K_N, K_M, K_P, K_Q, K_X, 8'h41};

        // Reset release with switches at 10
        sw_phy = 2'b10;
        repeat (5) @(negedge clk);
        rst = 1'b1;
        repeat (4) @(negedge clk);
        chk("rel_cfg", 32'(cfg), 32'h2);
        chk("rel_owner", 32'(owner), 32'd0);
        wait_quiet();
        chk("rel_reports", 32'(nstart), 32'd3);

        sw_phy = 2'b00;
        wait_quiet();

        // Two toggles back to back
        send(K_N);
        chk("n_cfg", 32'(cfg), 32'h2);
        send(K_M);
        chk("nm_cfg", 32'(cfg), 32'h3);
        chk("nm_owner", 32'(owner), 32'd1);
        wait_quiet();
        wait_quiet();

        // Ownership timeout
        send(K_N);
        c = 0;
        while (owner && c < 40) begin @(negedge clk); c++; end
        chk("timeout_cycles", 32'(c), 32'd16);
        wait_quiet();

        // Command colliding with a panel change
        @(negedge clk);
        sw_phy = 2'b01;
        @(negedge clk);
        @(negedge clk);
        rx_data = K_M;
        rx_done = 1'b1;
        @(negedge clk);
        rx_done = 1'b0;
        chk("arb_cfg", 32'(cfg), 32'h1);
        chk("arb_owner", 32'(owner), 32'd0);
        chk("arb_drop", 32'(cmd_drop), 32'd1);
        @(negedge clk);
        chk("arb_drop_width", 32'(cmd_drop), 32'd0);
        wait_quiet();

        // Three queries coalesce into two reports
        n0 = nstart;
        send(K_Q);
        send(K_Q);
        send(K_Q);
        wait_quiet();
        chk("query_reports", 32'(nstart - n0), 32'd6);

        // Unknown byte does not reset the timer
        send(K_N);
        c = 0;
        repeat (3) begin @(negedge clk); c++; end
        rx_data = K_X;
        rx_done = 1'b1;
        @(negedge clk);
        c++;
        rx_done = 1'b0;
        while (owner && c < 40) begin @(negedge clk); c++; end
        chk("unknown_timeout_cycles", 32'(c), 32'd16);
        wait_quiet();

        // Reset in the middle of a report
        n0 = nstart;
        send(K_Q);
        c = 0;
        while (nstart == n0 && c < 100) begin @(negedge clk); c++; end
        if (c >= 100) bound_fail("first_tx_start");
        @(negedge clk);
        rst = 1'b0;
        repeat (12) @(negedge clk);
        sw_phy = 2'b11;
        rst = 1'b1;
        wait_quiet();
        chk("post_rst_cfg", 32'(cfg), 32'h3);

        // Randomized traffic
        for (int i = 0; i < 400; i++) begin
            r = $urandom_range(0, 99);
            if (r < 45) begin
                @(negedge clk);
            end else if (r < 85) begin
                sel = $urandom_range(0, 5);
                send(cmds[sel]);
            end else begin
                @(negedge clk);
                sw_phy = 2'($urandom_range(0, 3));
            end
        end
        wait_quiet();
        wait_quiet();
        chk("leftover_bytes", 32'(byte_q.size()), 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

`default_nettype wire

// File: doc/sw_cmd_arbiter.md
# sw_cmd_arbiter

Owns the 2-bit run configuration (`cfg[1]` = mode, `cfg[0]` = unit) shared by the front-panel switches and the UART console. It arbitrates configuration requests from the two sources, tracks which source currently owns `cfg`, and returns ownership to the panel after a period with no UART activity. It also sequences a 3-byte status report onto the shared UART transmitter after every change or query. It sits between the UART RX/TX cores and the display/measurement datapath that consumes `cfg`.

## Interface
- `OWN_TIMEOUT`, default 500_000_000: clock cycles without an accepted UART command before ownership reverts to the panel (5 s at 100 MHz).
- `TO_W`, default 29: width of the timeout counter; must satisfy 2^TO_W ≥ OWN_TIMEOUT.

- `clk`  in  1  system clock
- `rst`  in  1  reset, asynchronous, active-low
- `rx_done`  in  1  one-cycle strobe, `rx_data` valid
- `rx_data`  in  8  received byte
- `sw_phy`  in  2  raw panel switches, asynchronous
- `tx_busy`  in  1  UART TX busy
- `tx_start`  out  1  one-cycle start strobe to UART TX
- `tx_data`  out  8  byte to transmit, held stable from `tx_start` until `tx_busy` falls
- `cfg`  out  2  active configuration
- `owner`  out  1  0 = panel, 1 = UART
- `cmd_drop`  out  1  one-cycle pulse when a UART command loses arbitration

## Operation
- `sw_phy` passes through a 2-flop synchronizer to give `sw_s`; `sw_prev` is `sw_s` delayed one cycle. `phy_chg` = (`sw_s` != `sw_prev`). `sw_prev` resets to 00.
- UART commands are sampled only on `rx_done`:
  - 'n' (8'h6E): toggle `cfg[1]`.
  - 'm' (8'h6D): toggle `cfg[0]`.
  - 'p' (8'h70): release ownership to the panel.
  - '?' (8'h3F): report only.
  - Any other byte is ignored: no report, no timer effect.
- On 'n' or 'm', the toggle applies to the current `cfg` value, `owner` becomes 1, and the timer clears.
- On 'p', `owner` becomes 0 and `cfg` takes `sw_s`.
- On `phy_chg`, `owner` becomes 0, `cfg` takes the new `sw_s`, and the timer clears.
- Arbitration when `phy_chg` and an 'n'/'m'/'p' command occur in the same cycle: the panel wins, the command is discarded, and `cmd_drop` pulses. A '?' in that same cycle is never dropped.
- Timeout:
  - The counter increments every cycle while `owner`=1.
  - When the count equals OWN_TIMEOUT-1, `owner` becomes 0, `cfg` takes `sw_s`, the counter clears, and a report is requested.
  - The counter holds at 0 while `owner`=0.
- Report request: raised by every `cfg` or `owner` change, by timeout expiry, and by '?'. Multiple requests in one cycle count as one.
- Report FSM states: IDLE, LOAD, START, ACK, DONE.
  - IDLE→LOAD when a request is present or `pend`=1; clear `pend`.
  - LOAD snapshots the bytes {"0"+`cfg[1]`, "0"+`cfg[0]`, 8'h0A}, sets the index to 0, then →START.
  - START: when `tx_busy`=0, drive `tx_data`, pulse `tx_start` for 1 cycle, then →ACK.
  - ACK: wait for `tx_busy`=1, then →DONE.
  - DONE: wait for `tx_busy`=0. If index=2, →IDLE; otherwise increment the index and →START.
- A request arriving in any state other than IDLE sets `pend`. Requests coalesce, so at most one extra report is queued, and it carries the `cfg` value at its own LOAD.

## Timing
- Reset values: `cfg`=00, `owner`=0, `tx_start`=0, `tx_data`=8'h00, `cmd_drop`=0, FSM=IDLE, `pend`=0, timer=0, synchronizer and `sw_prev`=00.
- A nonzero `sw_phy` at reset release therefore produces one `phy_chg` and one report.
- `cfg`, `owner` and `cmd_drop` are registered and update on the cycle after the `rx_done` or `phy_chg` cycle.
- `sw_phy` to `cfg` latency: 3–4 cycles (synchronizer plus register).
- `tx_start` occurs no earlier than 2 cycles after the request cycle (IDLE→LOAD→START).
- Reset asserted mid-report aborts the report immediately: `tx_start` low, queued report discarded.

## Test plan
- Release reset with `sw_phy`=10 → `cfg`=10 and `owner`=0 within 4 cycles; report bytes "1","0",0x0A, each with one `tx_start` under a modelled busy.
- `rx_data`='n' then 'm' with `sw_phy`=00 → `cfg`=10, then 11; `owner`=1; two reports, the second reading "1","1",0x0A.
- With OWN_TIMEOUT=16, `owner`=1 and no further rx → exactly 16 cycles later `owner`=0, `cfg`=`sw_s`, one report.
- 'm' on `rx_done` in the same cycle that `phy_chg` fires → `cfg`=new `sw_s`, `owner`=0, `cmd_drop`=1 for exactly 1 cycle.
- Three '?' commands while the first report is still transmitting → exactly 2 reports total; `tx_start` is never asserted while `tx_busy`=1.
- Unknown byte 'x' while `owner`=1 → no report, and the timer keeps counting without clearing.
